// File: rtl/gpu_pkg.sv
// Shared definitions for the per-thread register bank and its GPU-side command sequencer:
// register byte offsets, control/status field positions and the sequencer state encoding.
package gpu_pkg;

    localparam int THREAD_ID_OFS = 0;
    localparam int STATUS_OFS    = 4;
    localparam int CONTROL_OFS   = 8;
    localparam int CMD_BASE_OFS  = 12;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_N_LSB     = 8;
    localparam int CTRL_N_MSB     = 15;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_ERROR_BIT = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_MSB = 15;

    typedef enum logic [3:0] {
        SEQ_WAIT,
        SEQ_POLL_RD,
        SEQ_POLL_CHK,
        SEQ_ACK,
        SEQ_STAT_BUSY,
        SEQ_FETCH,
        SEQ_ISSUE,
        SEQ_PROG,
        SEQ_STAT
    } seq_state_t;

endpackage

// File: rtl/thread_command_sequencer.sv
// GPU-side port B initiator: polls the control word, fetches the command list and issues each
// 3-word command over valid/ready, reporting progress and completion in the status word.
//
// state      | meaning
// WAIT       | poll timer counting down; polls once it reaches 0 and enable=1
// POLL_RD    | read strobe on the control word
// POLL_CHK   | control word on rd_data; start=1 latches n
// ACK        | clear the start byte of the control word
// STAT_BUSY  | status busy=1, count 0
// FETCH      | three reads of command k, each captured one cycle later
// ISSUE      | cmd_valid held until the pipeline accepts command k
// PROG       | status busy=1 with the updated completed count
// STAT       | final status (done/error), busy dropped
module thread_command_sequencer
    import gpu_pkg::*;
#(
    parameter int BYTES_PER_WORD    = 4,
    parameter int COMMAND_COUNT     = 4,
    parameter int BYTES_PER_COMMAND = 12,
    parameter int POLL_INTERVAL     = 16,
    localparam int WORD_BITS        = 8 * BYTES_PER_WORD,
    localparam int ADDR_BITS        = $clog2(12 + BYTES_PER_COMMAND * COMMAND_COUNT),
    localparam int IDX_BITS         = (COMMAND_COUNT > 1) ? $clog2(COMMAND_COUNT) : 1
) (
    input  logic                   port_b_clk,
    input  logic                   port_b_reset,
    input  logic                   enable,
    output logic [ADDR_BITS-1:0]   port_b_address,
    output logic                   port_b_rd_en,
    input  logic [WORD_BITS-1:0]   port_b_rd_data,
    output logic [WORD_BITS-1:0]   port_b_wr_data,
    output logic [BYTES_PER_WORD-1:0] port_b_wr_en,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [3*WORD_BITS-1:0] cmd_data,
    output logic [IDX_BITS-1:0]    cmd_index,
    output logic                   busy
);

    localparam int K_BITS   = $clog2(COMMAND_COUNT + 1);
    localparam int TMR_BITS = $clog2(POLL_INTERVAL + 1);
    localparam logic [TMR_BITS-1:0] TMR_RELOAD = TMR_BITS'(POLL_INTERVAL);

    seq_state_t          state_q, state_d;
    logic [TMR_BITS-1:0] timer_q, timer_d;
    logic [7:0]          n_q, n_d;
    logic [K_BITS-1:0]   k_q, k_d;
    logic [1:0]          wc_q, wc_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [ADDR_BITS-1:0]      addr_d;
    logic                      rd_en_d;
    logic [WORD_BITS-1:0]      wr_data_d;
    logic [BYTES_PER_WORD-1:0] wr_en_d;
    logic                      cmd_valid_d;
    logic [IDX_BITS-1:0]       cmd_index_d;
    logic                      busy_d;

    function automatic logic [WORD_BITS-1:0] status_word(input logic b, input logic d,
                                                         input logic e,
                                                         input logic [K_BITS-1:0] cnt);
        logic [WORD_BITS-1:0] w;
        w = '0;
        w[STAT_BUSY_BIT]  = b;
        w[STAT_DONE_BIT]  = d;
        w[STAT_ERROR_BIT] = e;
        w[STAT_COUNT_MSB:STAT_COUNT_LSB] = 8'(cnt);
        return w;
    endfunction

    function automatic logic [ADDR_BITS-1:0] cmd_word_addr(input logic [K_BITS-1:0] k,
                                                           input logic [1:0] wc);
        return ADDR_BITS'(CMD_BASE_OFS + BYTES_PER_COMMAND * int'(k) + BYTES_PER_WORD * int'(wc));
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        n_d     = n_q;
        k_d     = k_q;
        wc_d    = wc_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            SEQ_WAIT: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (enable) begin
                    state_d = SEQ_POLL_RD;
                end
            end
            SEQ_POLL_RD: state_d = SEQ_POLL_CHK;
            SEQ_POLL_CHK: begin
                if (!port_b_rd_data[CTRL_START_BIT]) begin
                    timer_d = TMR_RELOAD;
                    state_d = SEQ_WAIT;
                end else begin
                    n_d     = port_b_rd_data[CTRL_N_MSB:CTRL_N_LSB];
                    k_d     = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = SEQ_ACK;
                end
            end
            SEQ_ACK: begin
                if (n_q > 8'(COMMAND_COUNT)) begin
                    err_d   = 1'b1;
                    state_d = SEQ_STAT;
                end else if (n_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = SEQ_STAT;
                end else begin
                    state_d = SEQ_STAT_BUSY;
                end
            end
            SEQ_STAT_BUSY: begin
                k_d     = '0;
                wc_d    = 2'd0;
                state_d = SEQ_FETCH;
            end
            // wc counts read issue (0..2) and capture (1..3) slots of the fetch pipeline
            SEQ_FETCH: begin
                wc_d = wc_q + 2'd1;
                if (wc_q == 2'd3) begin
                    state_d = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                if (cmd_valid && cmd_ready) begin
                    k_d     = k_q + 1'b1;
                    state_d = SEQ_PROG;
                end
            end
            SEQ_PROG: begin
                if (8'(k_q) == n_q) begin
                    done_d  = 1'b1;
                    state_d = SEQ_STAT;
                end else begin
                    wc_d    = 2'd0;
                    state_d = SEQ_FETCH;
                end
            end
            SEQ_STAT: begin
                timer_d = TMR_RELOAD;
                state_d = SEQ_WAIT;
            end
            default: state_d = SEQ_WAIT;
        endcase
    end

    // Outputs are decoded from the next state so that they are registered yet line up with it.
    always_comb begin
        addr_d      = '0;
        rd_en_d     = 1'b0;
        wr_data_d   = '0;
        wr_en_d     = '0;
        cmd_valid_d = 1'b0;
        cmd_index_d = cmd_index;
        busy_d      = !(state_d inside {SEQ_WAIT, SEQ_POLL_RD, SEQ_POLL_CHK});
        case (state_d)
            SEQ_POLL_RD: begin
                addr_d  = ADDR_BITS'(CONTROL_OFS);
                rd_en_d = 1'b1;
            end
            SEQ_ACK: begin
                addr_d  = ADDR_BITS'(CONTROL_OFS);
                wr_en_d = BYTES_PER_WORD'(1);
            end
            SEQ_STAT_BUSY: begin
                addr_d    = ADDR_BITS'(STATUS_OFS);
                wr_en_d   = '1;
                wr_data_d = status_word(1'b1, 1'b0, 1'b0, '0);
            end
            SEQ_FETCH: begin
                if (wc_d != 2'd3) begin
                    addr_d  = cmd_word_addr(k_d, wc_d);
                    rd_en_d = 1'b1;
                end
            end
            SEQ_ISSUE: begin
                cmd_valid_d = 1'b1;
                cmd_index_d = IDX_BITS'(k_d);
            end
            SEQ_PROG: begin
                addr_d    = ADDR_BITS'(STATUS_OFS);
                wr_en_d   = '1;
                wr_data_d = status_word(1'b1, 1'b0, 1'b0, k_d);
            end
            SEQ_STAT: begin
                addr_d    = ADDR_BITS'(STATUS_OFS);
                wr_en_d   = '1;
                wr_data_d = status_word(1'b0, done_d, err_d, k_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge port_b_clk) begin
        if (port_b_reset) begin
            state_q        <= SEQ_WAIT;
            timer_q        <= TMR_RELOAD;
            n_q            <= '0;
            k_q            <= '0;
            wc_q           <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            port_b_address <= '0;
            port_b_rd_en   <= 1'b0;
            port_b_wr_data <= '0;
            port_b_wr_en   <= '0;
            cmd_valid      <= 1'b0;
            cmd_index      <= '0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            n_q            <= n_d;
            k_q            <= k_d;
            wc_q           <= wc_d;
            done_q         <= done_d;
            err_q          <= err_d;
            port_b_address <= addr_d;
            port_b_rd_en   <= rd_en_d;
            port_b_wr_data <= wr_data_d;
            port_b_wr_en   <= wr_en_d;
            cmd_valid      <= cmd_valid_d;
            cmd_index      <= cmd_index_d;
            busy           <= busy_d;
        end
    end

    always_ff @(posedge port_b_clk) begin
        if (port_b_reset) begin
            cmd_data <= '0;
        end else if (state_q == SEQ_FETCH) begin
            case (wc_q)
                2'd1: cmd_data[0 +: WORD_BITS]           <= port_b_rd_data;
                2'd2: cmd_data[WORD_BITS +: WORD_BITS]   <= port_b_rd_data;
                2'd3: cmd_data[2*WORD_BITS +: WORD_BITS] <= port_b_rd_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_thread_command_sequencer.sv
// Bench for thread_command_sequencer: register-bank model on port B, table-driven and random
// command lists checked against a list-level model of the expected status/command traffic.
module tb_thread_command_sequencer;

    localparam int PI = 16;
    localparam int CC = 4;

    logic        port_b_clk = 1'b0;
    logic        port_b_reset = 1'b1;
    logic        enable = 1'b0;
    logic [5:0]  port_b_address;
    logic        port_b_rd_en;
    logic [31:0] port_b_rd_data = '0;
    logic [31:0] port_b_wr_data;
    logic [3:0]  port_b_wr_en;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [95:0] cmd_data;
    logic [1:0]  cmd_index;
    logic        busy;

    always #5 port_b_clk = ~port_b_clk;

    thread_command_sequencer #(
        .BYTES_PER_WORD(4), .COMMAND_COUNT(CC), .BYTES_PER_COMMAND(12), .POLL_INTERVAL(PI)
    ) dut (
        .port_b_clk(port_b_clk), .port_b_reset(port_b_reset), .enable(enable),
        .port_b_address(port_b_address), .port_b_rd_en(port_b_rd_en),
        .port_b_rd_data(port_b_rd_data), .port_b_wr_data(port_b_wr_data),
        .port_b_wr_en(port_b_wr_en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_index(cmd_index), .busy(busy)
    );

    typedef struct packed {
        logic [1:0]  idx;
        logic [95:0] data;
    } cmd_rec_t;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] final_status;
        int          n_cmds;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem [16] = '{default: 32'h0};
    logic        host_we = 1'b0;
    int          host_idx = 0;
    logic [31:0] host_wdata = '0;
    int          rd_count = 0;
    int          ready_mode = 0;

    logic [35:0] status_log [$];
    logic [35:0] ctrl_log [$];
    cmd_rec_t    cmd_log [$];
    logic [35:0] exp_status [$];
    cmd_rec_t    exp_cmds [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Register bank: 1-cycle read latency, byte-enabled writes, host back door for the CPU side.
    always @(posedge port_b_clk) begin : bank
        logic [31:0] m;
        if (host_we) mem[host_idx] <= host_wdata;
        if (port_b_rd_en) begin
            port_b_rd_data <= mem[port_b_address[5:2]];
            rd_count <= rd_count + 1;
        end
        if (port_b_wr_en != 4'd0) begin
            m = mem[port_b_address[5:2]];
            for (int b = 0; b < 4; b++)
                if (port_b_wr_en[b]) m[8*b +: 8] = port_b_wr_data[8*b +: 8];
            mem[port_b_address[5:2]] <= m;
            if (port_b_address == 6'd4) status_log.push_back({port_b_wr_en, port_b_wr_data});
            if (port_b_address == 6'd8) ctrl_log.push_back({port_b_wr_en, port_b_wr_data});
        end
    end

    always @(posedge port_b_clk) begin
        #1;
        case (ready_mode)
            0: cmd_ready = 1'b1;
            1: cmd_ready = 1'($urandom_range(0, 1));
            default: cmd_ready = 1'b0;
        endcase
    end

    logic        stall_prev = 1'b0;
    logic [95:0] hold_data = '0;
    logic [1:0]  hold_idx = '0;

    always @(negedge port_b_clk) begin
        if (port_b_rd_en || port_b_wr_en != 4'd0) begin
            check("one_strobe", 128'(port_b_rd_en && port_b_wr_en != 4'd0), 128'd0);
            check("addr_aligned", 128'(port_b_address[1:0]), 128'd0);
        end
        if (port_b_reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 128'(cmd_valid), 128'd1);
                check("stall_data", 128'(cmd_data), 128'(hold_data));
                check("stall_index", 128'(cmd_index), 128'(hold_idx));
            end
            if (cmd_valid) begin
                check("issue_no_port_b", 128'({port_b_rd_en, port_b_wr_en}), 128'd0);
                if (cmd_ready) cmd_log.push_back({cmd_index, cmd_data});
            end
            stall_prev = cmd_valid && !cmd_ready;
            hold_data  = cmd_data;
            hold_idx   = cmd_index;
        end
    end

    task automatic host_write(input int idx, input logic [31:0] data);
        host_we = 1'b1;
        host_idx = idx;
        host_wdata = data;
        @(posedge port_b_clk);
        #1;
        host_we = 1'b0;
    endtask

    // Expected traffic from the command-list rules: status words in order and the commands issued.
    task automatic model(input logic [31:0] ctrl);
        int n;
        n = int'(ctrl[15:8]);
        exp_status.delete();
        exp_cmds.delete();
        if (!ctrl[0]) return;
        if (n > CC) begin
            exp_status.push_back({4'hF, 32'h004});
        end else if (n == 0) begin
            exp_status.push_back({4'hF, 32'h002});
        end else begin
            exp_status.push_back({4'hF, 32'h001});
            for (int i = 1; i <= n; i++) exp_status.push_back({4'hF, 32'(i * 256 + 1)});
            exp_status.push_back({4'hF, 32'(n * 256 + 2)});
            for (int i = 0; i < n; i++)
                exp_cmds.push_back({2'(i), mem[3+3*i+2], mem[3+3*i+1], mem[3+3*i]});
        end
    endtask

    task automatic run_seq(input logic [31:0] ctrl, input int rmode);
        int cyc;
        logic fin;
        ready_mode = rmode;
        status_log.delete();
        ctrl_log.delete();
        cmd_log.delete();
        host_write(2, ctrl);
        model(ctrl);
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 3000) begin
            @(posedge port_b_clk);
            #1;
            cyc++;
            if (status_log.size() > 0) fin = !status_log[status_log.size()-1][0];
        end
        check("seq_timeout", 128'(fin), 128'd1);
        check("busy_after", 128'(busy), 128'd0);
        check("status_count", 128'(status_log.size()), 128'(exp_status.size()));
        for (int i = 0; i < exp_status.size() && i < status_log.size(); i++)
            check($sformatf("status[%0d]", i), 128'(status_log[i]), 128'(exp_status[i]));
        check("cmd_count", 128'(cmd_log.size()), 128'(exp_cmds.size()));
        for (int i = 0; i < exp_cmds.size() && i < cmd_log.size(); i++)
            check($sformatf("cmd[%0d]", i), 128'(cmd_log[i]), 128'(exp_cmds[i]));
        check("ctrl_writes", 128'(ctrl_log.size()), 128'd1);
        if (ctrl_log.size() > 0) check("ctrl_ack", 128'(ctrl_log[0]), 128'({4'h1, 32'h0}));
        check("ctrl_after", 128'(mem[2]), 128'(ctrl & 32'hFFFF_FF00));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int cyc;
        int rd0;
        int n;
        vecs[0] = '{32'h0000_0201, 32'h202, 2};
        vecs[1] = '{32'h0000_0001, 32'h002, 0};
        vecs[2] = '{32'h0000_0501, 32'h004, 0};
        vecs[3] = '{32'h0000_0401, 32'h402, 4};
        vecs[4] = '{32'hABCD_0101, 32'h102, 1};

        enable = 1'b1;
        repeat (3) @(posedge port_b_clk);
        #1;
        check("reset_port_b", 128'({port_b_address, port_b_rd_en, port_b_wr_data, port_b_wr_en}), 128'd0);
        check("reset_cmd", 128'({cmd_valid, cmd_data, cmd_index, busy}), 128'd0);
        port_b_reset = 1'b0;
        repeat (PI) @(posedge port_b_clk);
        #1;
        check("no_early_poll", 128'(port_b_rd_en), 128'd0);
        @(posedge port_b_clk);
        #1;
        check("first_poll", 128'({port_b_rd_en, port_b_address}), 128'({1'b1, 6'd8}));

        for (int i = 0; i < 12; i++) host_write(3 + i, 32'(17 * (i + 1)));

        for (int v = 0; v < 5; v++) begin
            run_seq(vecs[v].ctrl, 0);
            if (status_log.size() > 0)
                check("final_status", 128'(status_log[status_log.size()-1][31:0]),
                      128'(vecs[v].final_status));
            check("issued", 128'(cmd_log.size()), 128'(vecs[v].n_cmds));
            if (v == 0 && cmd_log.size() == 2) begin
                check("cmd0_data", 128'(cmd_log[0].data), 128'({32'h33, 32'h22, 32'h11}));
                check("cmd1_data", 128'(cmd_log[1].data), 128'({32'h66, 32'h55, 32'h44}));
            end
        end

        // Stall in ISSUE, then reset while cmd_valid is high.
        ready_mode = 2;
        status_log.delete();
        ctrl_log.delete();
        cmd_log.delete();
        host_write(2, 32'h0000_0201);
        cyc = 0;
        while (!cmd_valid && cyc < 200) begin
            @(posedge port_b_clk);
            #1;
            cyc++;
        end
        check("issue_reached", 128'(cmd_valid), 128'd1);
        repeat (10) @(posedge port_b_clk);
        #1;
        check("stall_held", 128'({cmd_valid, busy}), 128'(2'b11));
        check("stall_status", 128'(status_log.size()), 128'd1);
        port_b_reset = 1'b1;
        @(posedge port_b_clk);
        #1;
        check("reset_drop_valid", 128'({cmd_valid, busy, port_b_wr_en}), 128'd0);
        port_b_reset = 1'b0;
        ready_mode = 0;
        repeat (PI) @(posedge port_b_clk);
        #1;
        check("repoll_early", 128'(port_b_rd_en), 128'd0);
        @(posedge port_b_clk);
        #1;
        check("repoll", 128'({port_b_rd_en, port_b_address}), 128'({1'b1, 6'd8}));
        repeat (40) @(posedge port_b_clk);
        #1;
        check("post_reset_status", 128'(status_log.size()), 128'd1);
        check("post_reset_ctrl", 128'(ctrl_log.size()), 128'd1);
        check("post_reset_cmds", 128'(cmd_log.size()), 128'd0);
        check("start_cleared", 128'(mem[2][0]), 128'd0);

        // enable=0 blocks polling even with start set.
        enable = 1'b0;
        repeat (20) @(posedge port_b_clk);
        #1;
        status_log.delete();
        host_write(2, 32'h0000_0301);
        rd0 = rd_count;
        repeat (100) @(posedge port_b_clk);
        #1;
        check("disabled_reads", 128'(rd_count - rd0), 128'd0);
        check("disabled_status", 128'(status_log.size()), 128'd0);
        enable = 1'b1;
        run_seq(32'h0000_0301, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 12; i++) host_write(3 + i, $urandom);
            n = $urandom_range(0, 6);
            run_seq({16'($urandom), 8'(n), 8'($urandom) | 8'h01}, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
